// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package shift_pkg;

    // Shift operation selector carried with every op through the pipe
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready operation bus of the barrel shifter: request side (in_*) and result side (out_*).
interface shift_pipe_if
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = $clog2(WIDTH)
);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_t          in_op;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    // Issuing side: presents operations and consumes results
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Shifter side: accepts operations and produces results
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditionally shifts by 2^STAGE, then registers the op
// in a single-entry slice that accepts whenever it is empty or its result moves on.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int STAGE = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,

    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [WIDTH-1:0]         up_data,
    input  shift_op_t                up_op,
    input  logic [$clog2(WIDTH)-1:0] up_shamt,
    input  logic [TAG_W-1:0]         up_tag,
    input  logic                     up_sign,

    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [WIDTH-1:0]         dn_data,
    output shift_op_t                dn_op,
    output logic [$clog2(WIDTH)-1:0] dn_shamt,
    output logic [TAG_W-1:0]         dn_tag,
    output logic                     dn_sign
);

    localparam int AMT = 1 << STAGE;

    logic                     valid_q;
    logic [WIDTH-1:0]         data_q;
    shift_op_t                op_q;
    logic [$clog2(WIDTH)-1:0] shamt_q;
    logic [TAG_W-1:0]         tag_q;
    logic                     sign_q;

    // Shift by exactly AMT; SRA fills from the sign captured at pipe entry
    function automatic logic [WIDTH-1:0] shift_step(input shift_op_t op,
                                                    input logic [WIDTH-1:0] d,
                                                    input logic sign);
        logic [WIDTH-1:0] r;
        r = d;
        unique case (op)
            SHIFT_SLL: r = d << AMT;
            SHIFT_SRL: r = d >> AMT;
            SHIFT_SRA: r = {{AMT{sign}}, d[WIDTH-1:AMT]};
            SHIFT_ROR: r = {d[AMT-1:0], d[WIDTH-1:AMT]};
        endcase
        return r;
    endfunction

    // Slot is free when empty or when its current op leaves this cycle
    assign up_ready = !valid_q || dn_ready;

    // Stage register: reset clears everything, flush drops the op, otherwise advance
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= SHIFT_SLL;
            shamt_q <= '0;
            tag_q   <= '0;
            sign_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q  <= up_shamt[STAGE] ? shift_step(up_op, up_data, up_sign) : up_data;
                op_q    <= up_op;
                shamt_q <= up_shamt;
                tag_q   <= up_tag;
                sign_q  <= up_sign;
            end
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_op    = op_q;
    assign dn_shamt = shamt_q;
    assign dn_tag   = tag_q;
    assign dn_sign  = sign_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR): one stage per shift-amount bit,
// per-stage backpressure, synchronous flush. Latency is SHAMT_W cycles, throughput 1 op/cycle.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    shift_pipe_if.slave  bus
);

    localparam int S = SHAMT_W;

    // Index k is the input of stage k; index S is the output of the last stage
    logic               vld   [0:S];
    logic               rdy   [0:S];
    logic [WIDTH-1:0]   data  [0:S];
    shift_op_t          op    [0:S];
    logic [SHAMT_W-1:0] shamt [0:S];
    logic [TAG_W-1:0]   tag   [0:S];
    logic               sign  [0:S];

    // Entry: the SRA fill bit is the operand MSB as it arrives
    assign vld[0]   = bus.in_valid;
    assign data[0]  = bus.in_data;
    assign op[0]    = bus.in_op;
    assign shamt[0] = bus.in_shamt;
    assign tag[0]   = bus.in_tag;
    assign sign[0]  = bus.in_data[WIDTH-1];

    // Flush wins over acceptance, so the input is refused in a flush cycle
    assign bus.in_ready = rdy[0] && !flush;
    assign rdy[S]       = bus.out_ready;

    for (genvar k = 0; k < S; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STAGE (k)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .flush    (flush),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (data[k]),
            .up_op    (op[k]),
            .up_shamt (shamt[k]),
            .up_tag   (tag[k]),
            .up_sign  (sign[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (data[k+1]),
            .dn_op    (op[k+1]),
            .dn_shamt (shamt[k+1]),
            .dn_tag   (tag[k+1]),
            .dn_sign  (sign[k+1])
        );
    end

    // Result comes straight from the last stage registers
    assign bus.out_valid = vld[S];
    assign bus.out_data  = data[S];
    assign bus.out_tag   = tag[S];

    // Op, shamt and sign are no longer needed once the last stage has shifted
    logic unused_tail;
    assign unused_tail = ^{op[S], shamt[S], sign[S]};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed vectors for latency, fill rules, backpressure, flush and reset,
// then a randomised run against a behavioural shift model with an in-order scoreboard.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int SHW   = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .SHAMT_W(SHW)) bus ();

    shift_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHW), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] ref_shift(input shift_op_t op, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [63:0] rot;
        rot = {d, d} >> sh;
        case (op)
            SHIFT_SLL: return d << sh;
            SHIFT_SRL: return d >> sh;
            SHIFT_SRA: return $signed(d) >>> sh;
            default:   return rot[31:0];
        endcase
    endfunction

    // One clock: drive inputs, look at the handshake just before the edge, move past the edge
    task automatic step(input logic iv, input logic [31:0] d, input logic [4:0] sh,
                        input shift_op_t op, input logic [4:0] tg, input logic ordy,
                        input logic fl, output logic acc, output logic ov,
                        output logic [31:0] od, output logic [4:0] ot);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_shamt  = sh;
        bus.in_op     = op;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        acc = iv && bus.in_ready;
        ov  = bus.out_valid;
        od  = bus.out_data;
        ot  = bus.out_tag;
        @(posedge clock);
        #1;
    endtask

    task automatic run_one(input string name, input shift_op_t op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [4:0] tg, input logic [31:0] exp);
        logic acc, ov;
        logic [31:0] od;
        logic [4:0] ot;
        int lat;
        step(1'b1, d, sh, op, tg, 1'b1, 1'b0, acc, ov, od, ot);
        check({name, "_acc"}, 64'(acc), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'd4);
        check({name, "_data"}, 64'(bus.out_data), 64'(exp));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tg));
    endtask

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc, ov;
        logic [31:0] od;
        logic [4:0] ot;
        shift_op_t   v_op [12];
        logic [31:0] v_d  [12];
        logic [4:0]  v_sh [12];
        logic [31:0] v_ex [12];
        logic [31:0] bp_d [6];
        int nacc, nres, nv, base;
        logic tag6_in;
        logic [4:0]  res_t [6];
        logic [31:0] res_d [6];
        int          res_c [6];
        exp_t q[$];
        exp_t e;
        logic stall_prev;
        logic [31:0] prev_d;
        logic [4:0] prev_t;

        // Reset
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_op = SHIFT_SLL;
        bus.in_tag = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed fill/wrap vectors, tag 3 throughout
        v_op[0]  = SHIFT_SRA; v_d[0]  = 32'h80000000; v_sh[0]  = 5'd8;  v_ex[0]  = 32'hFF800000;
        v_op[1]  = SHIFT_SRL; v_d[1]  = 32'h80000000; v_sh[1]  = 5'd8;  v_ex[1]  = 32'h00800000;
        v_op[2]  = SHIFT_SLL; v_d[2]  = 32'h00000001; v_sh[2]  = 5'd31; v_ex[2]  = 32'h80000000;
        v_op[3]  = SHIFT_ROR; v_d[3]  = 32'h12345678; v_sh[3]  = 5'd8;  v_ex[3]  = 32'h78123456;
        v_op[4]  = SHIFT_SLL; v_d[4]  = 32'hDEADBEEF; v_sh[4]  = 5'd0;  v_ex[4]  = 32'hDEADBEEF;
        v_op[5]  = SHIFT_SRL; v_d[5]  = 32'hDEADBEEF; v_sh[5]  = 5'd0;  v_ex[5]  = 32'hDEADBEEF;
        v_op[6]  = SHIFT_SRA; v_d[6]  = 32'hDEADBEEF; v_sh[6]  = 5'd0;  v_ex[6]  = 32'hDEADBEEF;
        v_op[7]  = SHIFT_ROR; v_d[7]  = 32'hDEADBEEF; v_sh[7]  = 5'd0;  v_ex[7]  = 32'hDEADBEEF;
        v_op[8]  = SHIFT_SRA; v_d[8]  = 32'hF0000000; v_sh[8]  = 5'd31; v_ex[8]  = 32'hFFFFFFFF;
        v_op[9]  = SHIFT_SRA; v_d[9]  = 32'h40000000; v_sh[9]  = 5'd31; v_ex[9]  = 32'h00000000;
        v_op[10] = SHIFT_ROR; v_d[10] = 32'h80000001; v_sh[10] = 5'd1;  v_ex[10] = 32'hC0000000;
        v_op[11] = SHIFT_SRL; v_d[11] = 32'hFFFFFFFF; v_sh[11] = 5'd31; v_ex[11] = 32'h00000001;
        for (int i = 0; i < 12; i++)
            run_one($sformatf("vec%0d", i), v_op[i], v_d[i], v_sh[i], 5'd3, v_ex[i]);
        step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);

        // Backpressure: six back-to-back SLL ops (data=tag, shamt=tag) into a stalled pipe
        bp_d[0] = 32'd2; bp_d[1] = 32'd8; bp_d[2] = 32'd24;
        bp_d[3] = 32'd64; bp_d[4] = 32'd160; bp_d[5] = 32'd384;
        nacc = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 32'(i), 5'(i), SHIFT_SLL, 5'(i), 1'b0, 1'b0, acc, ov, od, ot);
            if (acc) nacc++;
        end
        check("bp_accepts", 64'(nacc), 64'd5);
        check("bp_6th_refused", 64'(acc), 64'd0);
        repeat (3) step(1'b1, 32'd6, 5'd6, SHIFT_SLL, 5'd6, 1'b0, 1'b0, acc, ov, od, ot);
        check("bp_stall_ready", 64'(bus.in_ready), 64'd0);
        check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_tag", 64'(bus.out_tag), 64'd1);
        check("bp_hold_data", 64'(bus.out_data), 64'd2);
        tag6_in = 1'b0;
        nres = 0;
        for (int c = 0; c < 20 && nres < 6; c++) begin
            step(!tag6_in, 32'd6, 5'd6, SHIFT_SLL, 5'd6, 1'b1, 1'b0, acc, ov, od, ot);
            if (acc) tag6_in = 1'b1;
            if (ov) begin
                res_t[nres] = ot; res_d[nres] = od; res_c[nres] = c;
                nres++;
            end
        end
        check("bp_results", 64'(nres), 64'd6);
        for (int i = 0; i < nres; i++) begin
            check($sformatf("bp_tag%0d", i), 64'(res_t[i]), 64'(i + 1));
            check($sformatf("bp_data%0d", i), 64'(res_d[i]), 64'(bp_d[i]));
            check($sformatf("bp_cycle%0d", i), 64'(res_c[i] - res_c[0]), 64'(i));
        end

        // Flush with tags 1-3 in flight and tag 4 offered in the flush cycle
        for (int i = 1; i <= 3; i++)
            step(1'b1, 32'(i), 5'd0, SHIFT_SLL, 5'(i), 1'b1, 1'b0, acc, ov, od, ot);
        step(1'b1, 32'd4, 5'd0, SHIFT_SLL, 5'd4, 1'b1, 1'b1, acc, ov, od, ot);
        check("fl_refused", 64'(acc), 64'd0);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        run_one("fl_next", SHIFT_SRL, 32'h0000F000, 5'd12, 5'd7, 32'h0000000F);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);
            if (ov) nv++;
        end
        check("fl_no_stale", 64'(nv), 64'd1);

        // Reset with four ops in flight
        for (int i = 1; i <= 4; i++)
            step(1'b1, 32'(i), 5'd1, SHIFT_SLL, 5'(i), 1'b1, 1'b0, acc, ov, od, ot);
        reset_n = 1'b0;
        step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);
        check("mrst_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_data", 64'(bus.out_data), 64'd0);
        check("mrst_tag", 64'(bus.out_tag), 64'd0);
        reset_n = 1'b1;
        step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);
        check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 5'd0, SHIFT_SLL, 5'd0, 1'b1, 1'b0, acc, ov, od, ot);
            if (ov) nv++;
        end
        check("mrst_no_output", 64'(nv), 64'd0);

        // Random ops with random backpressure and occasional flush
        stall_prev = 1'b0;
        prev_d = '0;
        prev_t = '0;
        for (int c = 0; c < 3010; c++) begin
            logic iv, ordy, fl;
            logic [31:0] d;
            logic [4:0] sh, tg;
            shift_op_t op;
            if (stall_prev) begin
                check("rnd_hold_valid", 64'(bus.out_valid), 64'd1);
                check("rnd_hold_data", 64'(bus.out_data), 64'(prev_d));
                check("rnd_hold_tag", 64'(bus.out_tag), 64'(prev_t));
            end
            iv   = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (c < 3000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            fl   = (c < 3000) ? ($urandom_range(0, 49) == 0) : 1'b0;
            d    = $urandom;
            sh   = 5'($urandom_range(0, 31));
            tg   = 5'($urandom_range(0, 31));
            op   = shift_op_t'(2'($urandom_range(0, 3)));
            step(iv, d, sh, op, tg, ordy, fl, acc, ov, od, ot);
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected", 64'(ot), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    check("rnd_data", 64'(od), 64'(e.d));
                    check("rnd_tag", 64'(ot), 64'(e.t));
                end
            end
            if (fl) q.delete();
            else if (acc) q.push_back('{ref_shift(op, d, sh), tg});
            stall_prev = ov && !ordy && !fl;
            prev_d = od;
            prev_t = ot;
        end
        check("rnd_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
